// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Lets NUM_CH requesters share one embedded single-port synchronous VRAM.
// Channel 0 is the CPU memory controller; channels 1..NUM_CH-1 are GPU or
// blitter engines. One access is granted per cycle. A channel can lock the
// bus for exclusive bursts, and a watchdog breaks a lock that is held for
// LOCK_TIMEOUT consecutive cycles.
//
// Build option:
//   VRAM_ARB_FIXED_PRIO_EN  defined   -> lowest requesting index always wins
//                           undefined -> round-robin starting at r_rrPtr
//
// Ports (channel i occupies slice [i*W +: W] of the flattened buses):
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_req_en       per-channel access request, held until granted
//   i_req_write    per-channel 1 = write, 0 = read
//   i_req_lock     per-channel request or hold exclusive ownership
//   i_req_addr     per-channel word address
//   i_req_data_w   per-channel write data
//   o_gnt          combinational one-hot grant (zero while in reset)
//   o_rd_valid     registered one-hot, marks the owner of o_rd_data
//   o_rd_data      registered read data shared by all channels
//   o_lock_err     one-cycle pulse when the watchdog breaks a lock
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 2,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_CH-1:0]              i_req_en,
  input  logic [NUM_CH-1:0]              i_req_write,
  input  logic [NUM_CH-1:0]              i_req_lock,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_req_data_w,
  output logic [NUM_CH-1:0]              o_gnt,
  output logic [NUM_CH-1:0]              o_rd_valid,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic                           o_lock_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

`ifdef VRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arbState_t;

  arbState_t              r_state;
  arbState_t              w_nextState;
  logic [CH_W-1:0]        r_rrPtr;
  logic [CH_W-1:0]        w_nextRrPtr;
  logic [CH_W-1:0]        r_owner;
  logic [CH_W-1:0]        w_nextOwner;
  logic [CNT_W-1:0]       r_lockCnt;
  logic [CNT_W-1:0]       w_nextLockCnt;
  logic [NUM_CH-1:0]      r_blocked;
  logic [NUM_CH-1:0]      w_nextBlocked;
  logic                   r_lockErr;
  logic                   w_nextLockErr;
  logic [NUM_CH-1:0]      r_rdValid;
  logic [DATA_WIDTH-1:0]  r_rdData;

  logic                   w_gntValid;
  logic [CH_W-1:0]        w_gntIdx;
  logic [CH_W-1:0]        w_base;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [DATA_WIDTH-1:0]  w_wdata;

  logic [DATA_WIDTH-1:0]  r_mem [2**ADDR_WIDTH];

  // Successor channel index with wrap at NUM_CH (not at the power of two).
  function automatic logic [CH_W-1:0] nextCh(input logic [CH_W-1:0] ch);
    return (ch == LAST_CH) ? '0 : ch + 1'b1;
  endfunction

  assign w_base  = FIXED_PRIO ? '0 : r_rrPtr;
  assign w_addr  = i_req_addr[w_gntIdx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = i_req_data_w[w_gntIdx*DATA_WIDTH +: DATA_WIDTH];

  // Grant selection. While locked only the owner may be granted; otherwise
  // scan from the base pointer upward with wrap and take the first request.
  // Reset forces the grant off so nothing reaches the RAM during reset.
  always_comb begin
    w_gntValid = 1'b0;
    w_gntIdx   = '0;
    if (r_state == ST_LOCKED) begin
      if (i_req_en[r_owner]) begin
        w_gntValid = 1'b1;
        w_gntIdx   = r_owner;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_gntValid && i_req_en[CH_W'((int'(w_base) + k) % NUM_CH)]) begin
          w_gntValid = 1'b1;
          w_gntIdx   = CH_W'((int'(w_base) + k) % NUM_CH);
        end
      end
    end
    if (!i_rst_n) begin
      w_gntValid = 1'b0;
    end
    o_gnt = '0;
    if (w_gntValid) begin
      o_gnt[w_gntIdx] = 1'b1;
    end
  end

  // Next-state logic for the lock FSM, the round-robin pointer and the
  // watchdog. A blocked bit drops as soon as its channel lets go of the lock
  // request; the watchdog only sets it while the request is still held, so
  // the two never collide.
  always_comb begin
    w_nextState   = r_state;
    w_nextRrPtr   = r_rrPtr;
    w_nextOwner   = r_owner;
    w_nextLockCnt = r_lockCnt;
    w_nextLockErr = 1'b0;
    w_nextBlocked = r_blocked & i_req_lock;
    case (r_state)
      ST_ARB: begin
        if (w_gntValid) begin
          if (!FIXED_PRIO) begin
            w_nextRrPtr = nextCh(w_gntIdx);
          end
          if (i_req_lock[w_gntIdx] && !r_blocked[w_gntIdx]) begin
            w_nextState   = ST_LOCKED;
            w_nextOwner   = w_gntIdx;
            w_nextLockCnt = '0;
          end
        end
      end
      ST_LOCKED: begin
        w_nextLockCnt = r_lockCnt + 1'b1;
        if (!i_req_lock[r_owner]) begin
          w_nextState = ST_ARB;
        end else if ((LOCK_TIMEOUT != 0) && (r_lockCnt == CNT_LAST)) begin
          w_nextState          = ST_ARB;
          w_nextLockErr        = 1'b1;
          w_nextBlocked[r_owner] = 1'b1;
          if (!FIXED_PRIO) begin
            w_nextRrPtr = nextCh(r_owner);
          end
        end
      end
      default: begin
        w_nextState = ST_ARB;
      end
    endcase
  end

  // State and read-port registers. Reads register the addressed word and
  // raise the requester's valid bit for exactly one cycle; the data itself
  // holds between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_ARB;
      r_rrPtr   <= '0;
      r_owner   <= '0;
      r_lockCnt <= '0;
      r_blocked <= '0;
      r_lockErr <= 1'b0;
      r_rdValid <= '0;
      r_rdData  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_rrPtr   <= w_nextRrPtr;
      r_owner   <= w_nextOwner;
      r_lockCnt <= w_nextLockCnt;
      r_blocked <= w_nextBlocked;
      r_lockErr <= w_nextLockErr;
      r_rdValid <= '0;
      if (w_gntValid && !i_req_write[w_gntIdx]) begin
        r_rdValid[w_gntIdx] <= 1'b1;
        r_rdData            <= r_mem[w_addr];
      end
    end
  end

  // VRAM write port. Contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (w_gntValid && i_req_write[w_gntIdx]) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  assign o_rd_valid = r_rdValid;
  assign o_rd_data  = r_rdData;
  assign o_lock_err = r_lockErr;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed self-checking bench for vram_arbiter with two channels and an
// 8-cycle lock watchdog. Expected values are worked out by hand from the
// arbitration, lock and read-latency rules.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NCH = 2;
  localparam int LT = 8;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NCH-1:0]    reqEn;
  logic [NCH-1:0]    reqWrite;
  logic [NCH-1:0]    reqLock;
  logic [NCH*AW-1:0] reqAddr;
  logic [NCH*DW-1:0] reqDataW;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    rdValid;
  logic [DW-1:0]     rdData;
  logic              lockErr;

  int errCount   = 0;
  int checkCount = 0;

  logic [1:0] expGnt;
  logic [1:0] prevGnt;

  vram_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .NUM_CH       (NCH),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_req_en     (reqEn),
    .i_req_write  (reqWrite),
    .i_req_lock   (reqLock),
    .i_req_addr   (reqAddr),
    .i_req_data_w (reqDataW),
    .o_gnt        (gnt),
    .o_rd_valid   (rdValid),
    .o_rd_data    (rdData),
    .o_lock_err   (lockErr)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle's worth of request inputs for both channels.
  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] wr,
                               input logic [1:0] lock,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    reqEn    = en;
    reqWrite = wr;
    reqLock  = lock;
    reqAddr  = {a1, a0};
    reqDataW = {d1, d0};
  endtask

  // Advances to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, write/read, round-robin, write-first,
  // lock burst, watchdog, and reset in the middle of a locked read.
  initial begin
    rstN = 1'b0;
    applyStimulus(2'b11, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("rst_gnt_forced", 32'(gnt), 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("rst_rd_valid", 32'(rdValid), 32'h0);
    checkOutput("rst_rd_data", 32'(rdData), 32'h0);
    checkOutput("rst_lock_err", 32'(lockErr), 32'h0);
    rstN = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    nextCycle();

    applyStimulus(2'b01, 2'b01, 2'b00, 10'h005, 10'h000, 16'hBEEF, 16'h0);
    #1;
    checkOutput("wr_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b10, 2'b00, 2'b00, 10'h000, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("rd_gnt", 32'(gnt), 32'h2);
    checkOutput("wr_no_rd_valid", 32'(rdValid), 32'h0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("rd_valid", 32'(rdValid), 32'h2);
    checkOutput("rd_data", 32'(rdData), 32'hBEEF);
    nextCycle();
    checkOutput("rd_valid_pulse", 32'(rdValid), 32'h0);
    checkOutput("rd_data_hold", 32'(rdData), 32'hBEEF);

    prevGnt = 2'b00;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 10'h005, 10'h005, 16'h0, 16'h0);
      #1;
`ifdef VRAM_ARB_FIXED_PRIO_EN
      expGnt = 2'b01;
`else
      expGnt = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
      checkOutput("rr_gnt", 32'(gnt), 32'(expGnt));
      if (i > 0) begin
        checkOutput("rr_rd_valid", 32'(rdValid), 32'(prevGnt));
      end
      prevGnt = expGnt;
      nextCycle();
    end

    applyStimulus(2'b10, 2'b10, 2'b00, 10'h000, 10'h007, 16'h0, 16'h1234);
    #1;
    checkOutput("wf_wr_gnt", 32'(gnt), 32'h2);
    checkOutput("rr_rd_valid_last", 32'(rdValid), 32'(prevGnt));
    nextCycle();
    applyStimulus(2'b01, 2'b00, 2'b00, 10'h007, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("wf_rd_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("wf_rd_valid", 32'(rdValid), 32'h1);
    checkOutput("wf_rd_data", 32'(rdData), 32'h1234);
    nextCycle();

    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 0) ? 2'b10 : 2'b11, 2'b10, (i == 3) ? 2'b00 : 2'b10,
                    10'h005, AW'(10'h010 + i), 16'h0, DW'(16'hA0A0 + i));
      #1;
      checkOutput("lock_burst_gnt", 32'(gnt), 32'h2);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, AW'(10'h010 + i), 10'h000, 16'h0, 16'h0);
      #1;
      checkOutput("readback_gnt", 32'(gnt), 32'h1);
      if (i > 0) begin
        checkOutput("readback_data", 32'(rdData), 32'(16'hA0A0 + i - 1));
      end
      nextCycle();
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("readback_last_valid", 32'(rdValid), 32'h1);
    checkOutput("readback_last_data", 32'(rdData), 32'hA0A3);
    nextCycle();

    applyStimulus(2'b10, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("wd_lock_gnt", 32'(gnt), 32'h2);
    nextCycle();
    for (int i = 0; i < LT; i++) begin
      applyStimulus(2'b11, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
      #1;
      checkOutput("wd_locked_gnt", 32'(gnt), 32'h2);
      checkOutput("wd_no_err_yet", 32'(lockErr), 32'h0);
      nextCycle();
    end
    applyStimulus(2'b11, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("wd_lock_err", 32'(lockErr), 32'h1);
    checkOutput("wd_ch0_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b10, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("wd_err_pulse_end", 32'(lockErr), 32'h0);
    checkOutput("wd_blocked_gnt", 32'(gnt), 32'h2);
    nextCycle();
    applyStimulus(2'b11, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("wd_no_relock_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    nextCycle();
    applyStimulus(2'b10, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("relock_grant", 32'(gnt), 32'h2);
    nextCycle();
    applyStimulus(2'b11, 2'b00, 2'b10, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("relock_held_gnt", 32'(gnt), 32'h2);
    nextCycle();
    applyStimulus(2'b10, 2'b00, 2'b00, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("relock_release_gnt", 32'(gnt), 32'h2);
    nextCycle();

    applyStimulus(2'b10, 2'b00, 2'b10, 10'h000, 10'h010, 16'h0, 16'h0);
    #1;
    checkOutput("mid_lock_grant", 32'(gnt), 32'h2);
    nextCycle();
    applyStimulus(2'b10, 2'b00, 2'b10, 10'h000, 10'h011, 16'h0, 16'h0);
    #1;
    checkOutput("mid_lock_read_gnt", 32'(gnt), 32'h2);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_gnt_forced", 32'(gnt), 32'h0);
    nextCycle();
    nextCycle();
    rstN = 1'b1;
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("post_rst_rd_valid", 32'(rdValid), 32'h0);
    checkOutput("post_rst_rd_data", 32'(rdData), 32'h0);
    checkOutput("post_rst_lock_err", 32'(lockErr), 32'h0);
    nextCycle();
    applyStimulus(2'b11, 2'b00, 2'b00, 10'h005, 10'h005, 16'h0, 16'h0);
    #1;
    checkOutput("post_rst_arb_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 16'h0);
    #1;
    checkOutput("post_rst_rd_valid2", 32'(rdValid), 32'h1);
    checkOutput("post_rst_ram_kept", 32'(rdData), 32'hBEEF);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
